quant8_row_recip: RTL
=====================

// Module: quant8_row_recip
// PURPOSE
//  Quantizer stage directly downstream of the 8-point DCT row engine. Takes one row of 8 signed
//  fixed-point DCT coefficients per beat. Multiplies each by a reciprocal quantization value
//  (1/Q, looked up by row and column). Rounds, saturates, and emits 8 quantized coefficients
//  for the zigzag/entropy stage. 3-stage pipeline with valid/ready flow control.
// PARAMETERS
//  IN_W    32  input coefficient width, signed two's complement
//  FRAC     8  fractional bits of input coefficients
//  Q_W     16  reciprocal table entry width, unsigned
//  Q_FRAC  16  fractional bits of reciprocal (recip = round(2^Q_FRAC / Q))
//  OUT_W   12  output quantized coefficient width, signed
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input row valid
//  in_ready   out  1          stage can accept a row
//  in_sof     in   1          first row of an 8x8 block (resyncs row counter)
//  in_data    in   8xIN_W     DCT coefficients, index = column 0..7
//  out_valid  out  1          output row valid
//  out_ready  in   1          downstream accepts
//  out_row    out  3          row index of output row within block
//  out_last   out  1          high with row 7 (end of block)
//  out_data   out  8xOUT_W    quantized coefficients
// BEHAVIOUR
//  - Reset: out_valid=0, out_row=0, out_last=0, out_data=0, row counter=0, all stage valids=0.
//  - Reset dominates any handshake in the same cycle. Reset mid-block drops all in-flight rows.
//  - Handshake: transfer when valid&&ready. stall = out_valid && !out_ready.
//  - Pipeline advances (all stages together) when !stall. in_ready = !stall (combinational).
//  - Output held stable while stall. Bubbles are not collapsed.
//  - Latency: 3 cycles from accepted input to out_valid when there is no stall.
//  - Row counter (3b): a beat accepted with in_sof=1 uses row 0 and sets counter=1.
//    Otherwise the beat uses the counter value, then counter increments and wraps 7->0.
//  - out_last = (out_row==7).
//  - S1: register data, row, and in_sof. Look up recip[row][col] for each of the 8 lanes.
//  - S2: p = x * $signed({1'b0,recip}), IN_W+Q_W+1 bits.
//  - S3: S = FRAC+Q_FRAC. r = (p + (p<0 ? 2^(S-1)-1 : 2^(S-1))) >>> S, i.e. round half away from zero.
//    Saturate r to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
//  - Default table: JPEG Annex K luminance Q table, row-major.
//    Reciprocals are computed at elaboration, with Q=0 treated as 1.
// CONFIGURATION
//  QUANT_TBL_WR_EN defined:
//    - Adds ports tbl_we (in,1), tbl_addr (in,6, = row*8+col), tbl_wdata (in,Q_W).
//    - Table is a register array; reset reloads the default reciprocals.
//    - A write is visible to rows entering S1 on the cycle after the write.
//    - A row entering S1 in the same cycle as a write to its row uses the old value.
//  Not defined:
//    - No extra ports; table is a constant ROM.
// STRUCTURE
//  - quant_pkg holds widths, the default Q table (64 entries), the recip function/localparam
//    array, and the rounding/saturation constants. It is shared with the dequant/IDCT side.
//  - Sub-module quant_lane: one coefficient's S2 multiply and S3 round/saturate.
//    Instantiated 8x; the parent owns S1, the row counter, the table, and flow control.
// TESTING (FRAC=8, Q_FRAC=16, OUT_W=12, default table)
//  1. sof row, col0 = 160.0 (40960), Q=16, recip 4096 -> out_data[0]=10, out_row=0, 3 cycles after accept.
//  2. col0 = -24.0 (-6144), Q=16 -> -2 (half away from zero).
//     col2 = 100.0 (25600), Q=10, recip 6554 -> 10.
//  3. col0 = 2^30, and col0 = -2^30 -> +2047 and -2048 (saturation).
//  4. 9 back-to-back rows, first with in_sof -> out_row 0..7,0; out_last only on the 8th.
//     Mid-block in_sof restarts at row 0.
//  5. out_ready low 5 cycles with 3 rows in flight -> out_data/out_row stable, in_ready=0.
//     After release, rows drain in order with no loss or duplication.
//  6. rst pulse with rows in flight -> out_valid=0 next cycle. Next row without sof gets row 0.
//     With QUANT_TBL_WR_EN: write addr 0 = 8192 -> following 160.0 gives 20.

Source files
------------

// File: rtl/quant8_row_recip_pkg.sv
// Shared quantizer constants: widths, default JPEG luminance table, reciprocal ROM
// and the rounding/saturation limits used by the quantize and dequantize paths.
package quant8_row_recip_pkg;

  localparam int unsigned IN_W   = 32;
  localparam int unsigned FRAC   = 8;
  localparam int unsigned Q_W    = 16;
  localparam int unsigned Q_FRAC = 16;
  localparam int unsigned OUT_W  = 12;
  localparam int unsigned S      = FRAC + Q_FRAC;
  localparam int unsigned P_W    = IN_W + Q_W + 1;

  typedef logic [2:0]            row_t;
  typedef logic [63:0][Q_W-1:0]  recip_tbl_t;

  localparam int unsigned Q_DEFAULT [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  // Q=0 is treated as 1; a reciprocal that does not fit Q_W bits clamps to all-ones.
  function automatic logic [Q_W-1:0] recip_of(input int unsigned q);
    longint unsigned qq;
    longint unsigned r;
    longint unsigned lim;
    qq  = (q == 0) ? 64'd1 : longint'(q);
    r   = ((64'd1 << Q_FRAC) + qq / 2) / qq;
    lim = (64'd1 << Q_W) - 1;
    return (r > lim) ? Q_W'(lim) : Q_W'(r);
  endfunction

  function automatic recip_tbl_t build_recip();
    recip_tbl_t t;
    for (int unsigned i = 0; i < 64; i++) begin
      t[i] = recip_of(Q_DEFAULT[i]);
    end
    return t;
  endfunction

  localparam recip_tbl_t RECIP_DEFAULT = build_recip();

  localparam logic signed [P_W-1:0] RND_HALF    = P_W'(longint'(1) << (S - 1));
  localparam logic signed [P_W-1:0] RND_HALF_M1 = P_W'((longint'(1) << (S - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_MAX     = P_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_MIN     = P_W'(-(longint'(1) << (OUT_W - 1)));

endpackage

// File: rtl/quant8_row_recip_if.sv
// Row streaming bus between the DCT row engine, the quantizer and the zigzag stage.
interface quant8_row_recip_if;
  import quant8_row_recip_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sof;
  logic [7:0][IN_W-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  row_t                   out_row;
  logic                   out_last;
  logic [7:0][OUT_W-1:0]  out_data;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_row, out_last, out_data
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_row, out_last, out_data
  );

endinterface

// File: rtl/quant8_row_recip_lane.sv
// One coefficient lane: S2 multiply by the reciprocal, S3 round half away from zero
// and saturate to OUT_W bits.
module quant8_row_recip_lane
  import quant8_row_recip_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  x_i,
  input  logic [Q_W-1:0]          recip_i,
  output logic signed [OUT_W-1:0] q_o
);

  logic signed [P_W-1:0]   p_q, p_d;
  logic signed [P_W-1:0]   x_ext, r_ext, sum, r;
  logic signed [OUT_W-1:0] q_q, q_d;

  always_comb begin
    x_ext = P_W'(x_i);
    r_ext = P_W'($signed({1'b0, recip_i}));
    sum   = p_q + (p_q[P_W-1] ? RND_HALF_M1 : RND_HALF);
    r     = sum >>> S;
    p_d   = p_q;
    q_d   = q_q;
    if (en) begin
      p_d = x_ext * r_ext;
      if (r > SAT_MAX) begin
        q_d = SAT_MAX[OUT_W-1:0];
      end else if (r < SAT_MIN) begin
        q_d = SAT_MIN[OUT_W-1:0];
      end else begin
        q_d = r[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      q_q <= '0;
    end else begin
      p_q <= p_d;
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/quant8_row_recip.sv
// Row quantizer after the 8-point DCT: 3-stage pipeline, 1/Q lookup by row and column.
// QUANT_TBL_WR_EN adds a writable reciprocal table (tbl_we/tbl_addr/tbl_wdata).
module quant8_row_recip
  import quant8_row_recip_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
`ifdef QUANT_TBL_WR_EN
  input  logic               tbl_we,
  input  logic [5:0]         tbl_addr,
  input  logic [Q_W-1:0]     tbl_wdata,
`endif
  quant8_row_recip_if.slave  bus
);

  logic                   stall, adv, accept;
  row_t                   row_in;
  row_t                   cnt_q, cnt_d;
  row_t                   row1_q, row1_d, row2_q, row2_d, out_row_q, out_row_d;
  logic                   v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  logic                   out_last_q, out_last_d;
  logic [7:0][IN_W-1:0]   x1_q, x1_d;
  logic [7:0][Q_W-1:0]    r1_q, r1_d;
  logic [7:0][OUT_W-1:0]  q_lane;
  recip_tbl_t             tbl;

`ifdef QUANT_TBL_WR_EN
  recip_tbl_t tbl_q, tbl_d;

  always_comb begin
    tbl_d = tbl_q;
    if (tbl_we) tbl_d[tbl_addr] = tbl_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) tbl_q <= RECIP_DEFAULT;
    else     tbl_q <= tbl_d;
  end

  assign tbl = tbl_q;
`else
  assign tbl = RECIP_DEFAULT;
`endif

  // Reciprocals are captured with the row so a same-cycle table write is not seen by it.
  always_comb begin
    stall      = ov_q && !bus.out_ready;
    adv        = !stall;
    accept     = bus.in_valid && adv;
    row_in     = bus.in_sof ? '0 : cnt_q;
    cnt_d      = cnt_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    ov_d       = ov_q;
    x1_d       = x1_q;
    r1_d       = r1_q;
    row1_d     = row1_q;
    row2_d     = row2_q;
    out_row_d  = out_row_q;
    out_last_d = out_last_q;
    if (accept) cnt_d = row_in + row_t'(1);
    if (adv) begin
      v1_d   = accept;
      v2_d   = v1_q;
      ov_d   = v2_q;
      x1_d   = bus.in_data;
      row1_d = row_in;
      for (int unsigned i = 0; i < 8; i++) begin
        r1_d[i] = tbl[{row_in, 3'(i)}];
      end
      row2_d     = row1_q;
      out_row_d  = row2_q;
      out_last_d = (row2_q == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      ov_q       <= 1'b0;
      x1_q       <= '0;
      r1_q       <= '0;
      row1_q     <= '0;
      row2_q     <= '0;
      out_row_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      ov_q       <= ov_d;
      x1_q       <= x1_d;
      r1_q       <= r1_d;
      row1_q     <= row1_d;
      row2_q     <= row2_d;
      out_row_q  <= out_row_d;
      out_last_q <= out_last_d;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    quant8_row_recip_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .x_i     (x1_q[g]),
      .recip_i (r1_q[g]),
      .q_o     (q_lane[g])
    );
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = ov_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = q_lane;

endmodule
